gate_exerciser: RTL and testbench
=================================

# gate_exerciser

Clocked stimulus-and-check stage that feeds a 2-input combinational gate such as `and_gate` and consumes its output. On `start` it drives all four input combinations onto `A`/`B` in order, holds each for a programmable number of cycles, samples `Y`, and compares it against a parameterised truth table. At the end of the run it reports pass/fail, a per-vector failure mask and a mismatch count. It replaces hand-written `#10` delay stimulus with a synthesizable self-checking driver.

## Interface
- `HOLD_CYCLES`, default 4: cycles each vector is held; legal range ≥ 2.
- `EXPECT`, default 4'b1000: expected `Y` per vector; bit i is the expected value for {A,B} = i (AND gate).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `a_out`  out  1  drives gate input A.
- `b_out`  out  1  drives gate input B.
- `y_in`  in  1  gate output Y, combinational from `a_out`/`b_out`.
- `busy`  out  1  high while vectors are being driven.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 if the last run had no mismatches; held until the next accepted start.
- `fail_mask`  out  4  bit i set if vector i mismatched; held like `pass`.
- `err_count`  out  3  number of mismatching vectors, 0 to 4; held like `pass`.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE: `a_out`=`b_out`=0, `busy`=0. `start`=1 goes to DRIVE with vector index `idx`=0 and hold counter `hcnt`=0. The same edge clears `pass`, `fail_mask` and `err_count`.
- DRIVE: {`a_out`,`b_out`} = `idx` (registered), `busy`=1, `hcnt` increments each cycle.
  - When `hcnt`==HOLD_CYCLES-1, `y_in` is sampled at that edge and compared with `EXPECT[idx]`.
  - On mismatch, set `fail_mask[idx]` and increment `err_count`.
  - Then reset `hcnt` to 0 and increment `idx`. After `idx`==3 is checked, go to DONE.
- DONE: exactly one cycle. `done`=1, `busy`=0, `a_out`=`b_out`=0, and `pass` = (`err_count`==0) with the final vector included. Then go to IDLE.
- `start` is ignored in DRIVE and DONE. A `start` held high from DONE into IDLE begins a new run on the first IDLE edge.
- `err_count` is 3 bits wide and cannot overflow (maximum 4).
- `y_in` is never sampled on the first cycle of a vector, so the gate has at least one full cycle to settle.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `err_count`=0; state IDLE; `idx`=0; `hcnt`=0.
- `start` sampled at edge t0:
  - `busy` rises and vector 00 appears after t0.
  - Vector i occupies cycles t0+i·H+1 to t0+(i+1)·H, where H = HOLD_CYCLES.
  - `done` is high for the cycle after edge t0+4H.
  - Results are valid in the same cycle as `done`.
- Run length: 4·H busy cycles plus 1 done cycle.
- `rst` asserted mid-run: at the next edge everything returns to reset values. No `done` pulse is produced and partial results are discarded.
- `rst` and `start` high together: `rst` wins.

## Structure
- Shared package `gate_test_pkg`:
  - state enum (IDLE/DRIVE/DONE);
  - `NUM_VECTORS`=4;
  - truth-table constants `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_XOR`=4'b0110, `TT_NAND`=4'b0111.
- One natural sub-module, `hold_timer`: a counter with load/clear and a terminal-count output at HOLD_CYCLES-1.
- Top level: FSM, index register, compare/accumulate logic.

## Test plan
- `and_gate` connected, H=4, `start` pulsed at cycle 0:
  - `busy` is high for 16 cycles;
  - A/B steps 00, 01, 10, 11 with 4 cycles each;
  - `done` is high at cycle 17 with `pass`=1, `fail_mask`=0, `err_count`=0.
- `y_in` driven by a NAND model with EXPECT=TT_AND: `fail_mask`=4'b1111, `err_count`=4, `pass`=0.
- `y_in` tied to 0: `fail_mask`=4'b1000, `err_count`=1, `pass`=0.
- `rst` pulsed at cycle 6 of a run:
  - all outputs 0 next cycle and no `done`;
  - a following `start` gives a complete, correct run.
- `start` pulsed during DRIVE: ignored, run length unchanged. `start` held high through DONE: a new run starts immediately and results clear on the accepting edge.
- H=2, EXPECT=TT_XOR with an XOR model: `done` 9 cycles after `start`, `pass`=1.

Source files
------------

// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared states, vector count and truth tables for gate exercising.
package gate_test_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam int NUM_VECTORS = 4;
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR = 4'b1110;
  localparam logic [3:0] TT_XOR = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
endpackage

// File: rtl/hold_timer.sv
// hold_timer: wrapping hold counter with clear; tc flags the last cycle of a hold.
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(HOLD_CYCLES);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(HOLD_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/gate_exerciser.sv
// gate_exerciser: drives all {A,B} vectors into a 2-input gate and checks Y against a truth table.
module gate_exerciser
  import gate_test_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter logic [3:0] EXPECT = TT_AND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);
  state_t state, next_state;
  logic [1:0] idx;
  logic tc, miss, last;
  assign miss = y_in != EXPECT[idx];
  assign last = idx == 2'(NUM_VECTORS - 1);
  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) timer (
    .clk(clk),
    .rst(rst),
    .clear(state != DRIVE),
    .en(state == DRIVE),
    .tc(tc)
  );
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : next_state;
  end
  always_comb begin
    next_state = state == IDLE ? (start ? DRIVE : IDLE)
               : state == DRIVE ? (tc && last ? DONE : DRIVE)
               : IDLE;
    busy = state == DRIVE;
    done = state == DONE;
    {a_out, b_out} = busy ? idx : 2'b00;
  end
  // y_in is only sampled on the final cycle of each hold, giving the gate time to settle
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      idx <= '0;
      pass <= 1'b0;
      fail_mask <= '0;
      err_count <= '0;
    end else if (state == DRIVE && tc) begin
      idx <= idx + 2'd1;
      if (miss) begin
        fail_mask[idx] <= 1'b1;
        err_count <= err_count + 3'd1;
      end
      if (last) pass <= err_count == 3'd0 && !miss;
    end
  end
endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: timeline model of the exerciser plus directed runs with literal expectations.
module tb_gate_exerciser;
  import gate_test_pkg::*;
  localparam int H = 4;
  localparam logic [3:0] EXP = TT_AND;
  logic clk = 0, rst = 1, start = 0, start2 = 0;
  logic a_out, b_out, y_in, busy, done, pass;
  logic [3:0] fail_mask;
  logic [2:0] err_count;
  logic a2, b2, y2, busy2, done2, pass2;
  logic [3:0] mask2;
  logic [2:0] err2;
  int mode = 0;
  int total = 0, bad = 0;
  int k = -1;
  logic [3:0] r_mask = 0;
  int r_err = 0;
  logic r_pass = 0;

  always #5 clk = ~clk;

  // mode selects the gate on the bench side: 0 AND, 1 NAND, 2 tied low, 3 XOR
  function automatic logic gate_val(input int m, input logic a, input logic b);
    return m == 0 ? (a & b) : m == 1 ? ~(a & b) : m == 2 ? 1'b0 : (a ^ b);
  endfunction

  assign y_in = gate_val(mode, a_out, b_out);
  assign y2 = a2 ^ b2;

  gate_exerciser #(.HOLD_CYCLES(H), .EXPECT(EXP)) dut (
    .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask), .err_count(err_count)
  );

  gate_exerciser #(.HOLD_CYCLES(2), .EXPECT(TT_XOR)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_mask(mask2), .err_count(err2)
  );

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
    end
  endtask

  // k = cycle number within a run (1..4H busy, 4H+1 done, 4H+2 idle), -1 after reset
  always @(posedge clk) begin
    if (rst) begin
      k = -1;
      r_mask = 0;
      r_err = 0;
      r_pass = 0;
    end else if ((k < 0 || k >= 4 * H + 2) && start) k = 1;
    else if (k > 0 && k < 4 * H + 2) begin
      k++;
      if (k == 4 * H + 1) begin
        for (int i = 0; i < 4; i++) r_mask[i] = gate_val(mode, i[1], i[0]) != EXP[i];
        r_err = $countones(r_mask);
        r_pass = r_mask == 0;
      end
    end
  end

  always @(negedge clk) begin
    automatic bit eb = k >= 1 && k <= 4 * H;
    chk("busy", busy, eb);
    chk("ab", {a_out, b_out}, eb ? (k - 1) / H : 0);
    chk("done", done, k == 4 * H + 1);
    if (k < 0 || k > 4 * H) begin
      chk("pass", pass, r_pass);
      chk("mask", fail_mask, r_mask);
      chk("err", err_count, r_err);
    end else begin
      chk("pass_run", pass, 0);
      if (k <= H) begin
        chk("mask_clear", fail_mask, 0);
        chk("err_clear", err_count, 0);
      end
    end
  end

  task automatic run(input int poke, input bit hold, output int cyc, output int bc);
    cyc = 0;
    bc = 0;
    @(negedge clk) start = 1;
    while (cyc < 80) begin
      @(negedge clk);
      cyc++;
      start = hold || (cyc == poke);
      if (busy) bc++;
      if (done) break;
    end
    chk("run_done", done, 1);
  endtask

  initial begin
    int c, b;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ab", {a_out, b_out}, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mask", fail_mask, 0);
    chk("rst_err", err_count, 0);
    mode = 0;
    run(0, 0, c, b);
    chk("and_cycles", c, 17);
    chk("and_busy", b, 16);
    chk("and_pass", pass, 1);
    chk("and_mask", fail_mask, 0);
    chk("and_err", err_count, 0);
    mode = 1;
    run(0, 0, c, b);
    chk("nand_mask", fail_mask, 15);
    chk("nand_err", err_count, 4);
    chk("nand_pass", pass, 0);
    mode = 2;
    run(0, 0, c, b);
    chk("zero_mask", fail_mask, 8);
    chk("zero_err", err_count, 1);
    chk("zero_pass", pass, 0);
    mode = 1;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (5) @(negedge clk);
    chk("mid_mask_before", fail_mask, 1);
    rst = 1;
    @(negedge clk) rst = 0;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_mask", fail_mask, 0);
    chk("mid_err", err_count, 0);
    repeat (20) @(negedge clk);
    mode = 0;
    run(0, 0, c, b);
    chk("after_rst_pass", pass, 1);
    run(5, 0, c, b);
    chk("poke_cycles", c, 17);
    chk("poke_busy", b, 16);
    run(0, 1, c, b);
    chk("hold_cycles", c, 17);
    @(negedge clk);
    chk("hold_idle_busy", busy, 0);
    chk("hold_idle_pass", pass, 1);
    @(negedge clk) start = 0;
    chk("hold_restart_busy", busy, 1);
    chk("hold_restart_pass", pass, 0);
    c = 1;
    while (!done && c < 80) begin
      @(negedge clk);
      c++;
    end
    chk("hold_run_cycles", c, 17);
    chk("hold_run_pass", pass, 1);
    c = 0;
    b = 0;
    @(negedge clk) start2 = 1;
    while (c < 40) begin
      @(negedge clk);
      start2 = 0;
      c++;
      if (busy2) b++;
      if (done2) break;
    end
    chk("xor_done", done2, 1);
    chk("xor_cycles", c, 9);
    chk("xor_busy", b, 8);
    chk("xor_pass", pass2, 1);
    chk("xor_mask", mask2, 0);
    chk("xor_err", err2, 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
